// File: rtl/sd_lba_arbiter.sv
// sd_lba_arbiter: shares the single SD block port of the IO block between NDEV
// disk controllers. Round-robin, one sector transfer per grant. sd_ack comes
// from the SPI_SCK domain and is synchronised into clk_sys before use.
// Optional watchdog: define SD_ARB_TIMEOUT_EN to abort a transfer stuck in
// REQ/XFER for TIMEOUT cycles (flagged on dev_err).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transfer; round-robin scan of pending requests
// REQ   | sd_rd/sd_wr held with latched sd_lba; waits for a fresh ack_s rise
// XFER  | ARM owns the sector; sd_buff_wr routed to owner; waits ack_s fall
// DONE  | one-cycle dev_done pulse to the owner
module sd_lba_arbiter #(
    parameter int          NDEV        = 2,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 32'd16777216
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [32*NDEV-1:0]   dev_lba,
    input  logic [NDEV-1:0]      dev_rd,
    input  logic [NDEV-1:0]      dev_wr,
    output logic [NDEV-1:0]      dev_ack,
    output logic [NDEV-1:0]      dev_done,
    output logic                 dev_err,
    output logic [NDEV-1:0]      dev_buff_wr,
    input  logic [8*NDEV-1:0]    dev_buff_din,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    input  logic                 sd_buff_wr,
    output logic [7:0]           sd_buff_din,
    output logic [2:0]           owner
);

    if (NDEV < 2 || NDEV > 8 || SYNC_STAGES < 1 || TIMEOUT < 2) begin : g_bad_param
        $error("sd_lba_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [NDEV-1:0]        pending;
    logic                   grant_hit;
    logic [2:0]             grant_idx;
    logic                   hi_hit;
    logic [2:0]             hi_idx;
    logic                   lo_hit;
    logic [2:0]             lo_idx;
    logic [31:0]            grant_lba;
    logic                   grant_rd;
    logic [2:0]             rr_ptr;
    logic                   op_rd;
    logic                   ack_armed;
    logic                   timeout_hit;

    assign pending = dev_rd | dev_wr;
    assign ack_s   = ack_sync[SYNC_STAGES-1];

    // Bring the SPI_SCK-domain ack into clk_sys through a plain flop chain.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= (ack_sync << 1) | SYNC_STAGES'(sd_ack);
        end
    end

    // Round-robin pick: lowest pending index at or above rr_ptr, else wrap to lowest overall.
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_hit = 1'b0;
        lo_idx = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lo_hit = 1'b1;
                lo_idx = 3'(i);
                if (3'(i) >= rr_ptr) begin
                    hi_hit = 1'b1;
                    hi_idx = 3'(i);
                end
            end
        end
        grant_hit = lo_hit;
        grant_idx = hi_hit ? hi_idx : lo_idx;
    end

    // Fetch LBA and operation of the candidate; read wins when both are requested.
    always_comb begin
        grant_lba = '0;
        grant_rd  = 1'b0;
        for (int i = 0; i < NDEV; i++) begin
            if (grant_idx == 3'(i)) begin
                grant_lba = dev_lba[32*i +: 32];
                grant_rd  = dev_rd[i];
            end
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT);

    logic [TMR_W-1:0] tmr;
    logic             err_q;

    // Watchdog down-counter, reloaded on every state change; terminal count at zero.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tmr <= TMR_W'(TIMEOUT - 1);
        end else if (state_nx != state) begin
            tmr <= TMR_W'(TIMEOUT - 1);
        end else if (tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
        end
    end

    assign timeout_hit = ((state == S_REQ) || (state == S_XFER)) && (tmr == '0);

    // Error flag: set by a watchdog abort, cleared by the next grant.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == S_IDLE && grant_hit) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign dev_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign dev_err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; REQ only accepts an ack that was seen low after entry.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (grant_hit)              state_nx = S_REQ;
            S_REQ:  if (timeout_hit)            state_nx = S_DONE;
                    else if (ack_s && ack_armed) state_nx = S_XFER;
            S_XFER: if (timeout_hit || !ack_s)  state_nx = S_DONE;
            S_DONE:                             state_nx = S_IDLE;
            default:                            state_nx = S_IDLE;
        endcase
    end

    // Grant bookkeeping: owner, round-robin pointer, latched LBA/op and ack edge qualifier.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            owner     <= '0;
            rr_ptr    <= '0;
            sd_lba    <= '0;
            op_rd     <= 1'b0;
            ack_armed <= 1'b0;
        end else if (state == S_IDLE && grant_hit) begin
            owner     <= grant_idx;
            rr_ptr    <= (grant_idx == 3'(NDEV - 1)) ? 3'd0 : grant_idx + 3'd1;
            sd_lba    <= grant_lba;
            op_rd     <= grant_rd;
            ack_armed <= 1'b0;
        end else if (state == S_REQ && !ack_s) begin
            ack_armed <= 1'b1;
        end
    end

    // Outputs decoded from state and owner; buffer strobe and data are steered combinationally.
    always_comb begin
        sd_rd       = (state == S_REQ) && op_rd;
        sd_wr       = (state == S_REQ) && !op_rd;
        dev_ack     = '0;
        dev_done    = '0;
        dev_buff_wr = '0;
        sd_buff_din = dev_buff_din[7:0];
        for (int i = 0; i < NDEV; i++) begin
            if (owner == 3'(i)) begin
                dev_ack[i]     = (state == S_XFER);
                dev_done[i]    = (state == S_DONE);
                dev_buff_wr[i] = (state == S_XFER) && sd_buff_wr;
                sd_buff_din    = dev_buff_din[8*i +: 8];
            end
        end
    end

endmodule
